// File: rtl/adc_acq_sm_cbuf_mw.sv
// ADC acquisition sequencer: on a qualified trigger it writes a fill header, then per
// waveform a header plus circular-buffer bursts, then a checksum, and waits for DDR3.
module adc_acq_sm_cbuf_mw #(
    parameter int ADDR_W          = 14,
    parameter int BURST_CNT_W     = 23,
    parameter int WFM_CNT_W       = 8,
    parameter int WORDS_PER_BURST = 4,
    parameter int SYNC_STAGES     = 4,
    parameter int TIMEOUT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             acq_enable,
    input  logic                   acq_trig,
    input  logic [BURST_CNT_W-1:0] burst_count,
    input  logic [WFM_CNT_W-1:0]   wfm_count,
    input  logic [ADDR_W-1:0]      trig_addr,
    input  logic                   trig_addr_empty,
    input  logic                   ddr3_wr_done,
    input  logic                   dummy_dat_reset_mode,
    output logic [1:0]             fill_type,
    output logic                   trig_pulse,
    output logic                   trig_addr_rd_en,
    output logic [ADDR_W-1:0]      circ_buf_rd_addr,
    output logic                   latch_circ_buf_dat,
    output logic                   adc_mux_fill_hdr_sel,
    output logic                   adc_mux_wfm_hdr_sel,
    output logic                   adc_mux_dat_sel,
    output logic                   adc_mux_checksum_select,
    output logic                   adc_mux_checksum_update,
    output logic                   adc_acq_out_valid,
    output logic                   address_cntr_en,
    output logic                   fill_cntr_en,
    output logic                   dummy_dat_reset,
    output logic                   acq_enabled,
    output logic                   acq_done,
    output logic                   sm_idle,
    output logic                   trig_addr_err
);

    localparam int                    WORD_W    = $clog2(WORDS_PER_BURST);
    localparam logic [WORD_W-1:0]     WORD_LAST = WORD_W'(WORDS_PER_BURST - 1);
    // Last empty cycle before timeout is cycle 2^TIMEOUT_W-1, i.e. count value 2^TIMEOUT_W-2.
    localparam logic [TIMEOUT_W-1:0]  TMO_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE, S_ARMED, S_FILL_HDR1, S_FILL_HDR2, S_WFM_WAIT, S_WFM_HDR1, S_WFM_HDR2,
        S_RUN, S_BURST_SEL, S_BURST_WR, S_WFM_END, S_CHECKSUM1, S_CHECKSUM2,
        S_DDR3_WAIT, S_DONE
    } state_t;

    typedef struct packed {
        logic sm_idle;
        logic acq_enabled;
        logic acq_done;
        logic fill_hdr_sel;
        logic wfm_hdr_sel;
        logic dat_sel;
        logic checksum_select;
        logic checksum_update;
        logic out_valid;
        logic address_cntr_en;
        logic fill_cntr_en;
        logic latch_dat;
        logic rd_en;
        logic dummy_reset;
    } ctrl_t;

    logic [1:0] rst_pipe;
    logic       rst_n;

    // NOTE: reset asserts asynchronously but is released through two flops, so no
    // downstream flop ever sees reset_n rise close to an active clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic [SYNC_STAGES-1:0][1:0] en_pipe;
    logic [SYNC_STAGES-1:0]      trig_pipe;
    logic [1:0]                  done_pipe;
    logic                        trig_prev;
    logic [1:0]                  en_s;
    logic                        trig_s, done_s, armed_s;

    assign en_s    = en_pipe[SYNC_STAGES-1];
    assign trig_s  = trig_pipe[SYNC_STAGES-1];
    assign done_s  = done_pipe[1];
    assign armed_s = |en_s;

    // NOTE: every sequential block uses non-blocking assignments so all flops update
    // from the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe    <= '0;
            trig_pipe  <= '0;
            done_pipe  <= '0;
            trig_prev  <= 1'b0;
            trig_pulse <= 1'b0;
        end else begin
            en_pipe    <= {en_pipe[SYNC_STAGES-2:0], acq_enable};
            trig_pipe  <= {trig_pipe[SYNC_STAGES-2:0], acq_trig};
            done_pipe  <= {done_pipe[0], ddr3_wr_done};
            trig_prev  <= trig_s;
            trig_pulse <= trig_s & ~trig_prev & armed_s;
        end
    end

    state_t                 state, state_nxt;
    logic [WFM_CNT_W-1:0]   wfm_rem;
    logic [BURST_CNT_W-1:0] burst_rem;
    logic [WORD_W-1:0]      word_cnt;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    ctrl_t                  ctrl, ctrl_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (armed_s) state_nxt = S_ARMED;
            S_ARMED:     if (trig_pulse)    state_nxt = S_FILL_HDR1;
                         else if (!armed_s) state_nxt = S_IDLE;
            S_FILL_HDR1: state_nxt = S_FILL_HDR2;
            S_FILL_HDR2: state_nxt = S_WFM_WAIT;
            S_WFM_WAIT:  if (!trig_addr_empty)        state_nxt = S_WFM_HDR1;
                         else if (tmo_cnt == TMO_LAST) state_nxt = S_CHECKSUM1;
            S_WFM_HDR1:  state_nxt = S_WFM_HDR2;
            S_WFM_HDR2:  state_nxt = S_RUN;
            S_RUN:       if (word_cnt == WORD_LAST) state_nxt = S_BURST_SEL;
            S_BURST_SEL: state_nxt = S_BURST_WR;
            S_BURST_WR:  state_nxt = (burst_rem == BURST_CNT_W'(1)) ? S_WFM_END : S_RUN;
            S_WFM_END:   state_nxt = (wfm_rem == WFM_CNT_W'(1)) ? S_CHECKSUM1 : S_WFM_WAIT;
            S_CHECKSUM1: state_nxt = S_CHECKSUM2;
            S_CHECKSUM2: state_nxt = S_DDR3_WAIT;
            S_DDR3_WAIT: if (done_s) state_nxt = S_DONE;
            S_DONE:      if (!(armed_s && trig_s)) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each is high exactly
    // while the state register holds the corresponding state.
    always_comb begin
        ctrl_nxt             = '0;
        ctrl_nxt.acq_enabled = !(state_nxt inside {S_IDLE, S_ARMED});
        case (state_nxt)
            S_IDLE:      ctrl_nxt.sm_idle = 1'b1;
            S_FILL_HDR1: ctrl_nxt.fill_hdr_sel = 1'b1;
            S_WFM_HDR1: begin
                ctrl_nxt.wfm_hdr_sel = 1'b1;
                ctrl_nxt.rd_en       = 1'b1;
                ctrl_nxt.dummy_reset = dummy_dat_reset_mode;
            end
            S_FILL_HDR2, S_WFM_HDR2, S_BURST_WR: begin
                ctrl_nxt.out_valid       = 1'b1;
                ctrl_nxt.address_cntr_en = 1'b1;
            end
            S_RUN:       ctrl_nxt.latch_dat = 1'b1;
            S_BURST_SEL: begin
                ctrl_nxt.dat_sel         = 1'b1;
                ctrl_nxt.checksum_update = 1'b1;
            end
            S_CHECKSUM1: ctrl_nxt.checksum_select = 1'b1;
            S_CHECKSUM2: begin
                ctrl_nxt.out_valid       = 1'b1;
                ctrl_nxt.address_cntr_en = 1'b1;
                ctrl_nxt.fill_cntr_en    = 1'b1;
            end
            S_DONE:      ctrl_nxt.acq_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl         <= '0;
            ctrl.sm_idle <= 1'b1;
        end else begin
            ctrl <= ctrl_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_type        <= '0;
            wfm_rem          <= '0;
            burst_rem        <= '0;
            word_cnt         <= '0;
            tmo_cnt          <= '0;
            circ_buf_rd_addr <= '0;
            trig_addr_err    <= 1'b0;
        end else begin
            case (state)
                S_ARMED: if (trig_pulse) begin
                    fill_type     <= en_s;
                    wfm_rem       <= (wfm_count == '0) ? WFM_CNT_W'(1) : wfm_count;
                    trig_addr_err <= 1'b0;
                end
                S_WFM_WAIT: begin
                    if (!trig_addr_empty) begin
                        circ_buf_rd_addr <= trig_addr;
                        burst_rem        <= (burst_count == '0) ? BURST_CNT_W'(1) : burst_count;
                        tmo_cnt          <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        trig_addr_err <= 1'b1;
                        tmo_cnt       <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WFM_HDR2: circ_buf_rd_addr <= circ_buf_rd_addr + 1'b1;
                S_RUN: begin
                    circ_buf_rd_addr <= circ_buf_rd_addr + 1'b1;
                    word_cnt         <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
                end
                S_BURST_WR: burst_rem <= burst_rem - 1'b1;
                S_WFM_END:  wfm_rem   <= wfm_rem - 1'b1;
                default: ;
            endcase
        end
    end

    assign sm_idle                 = ctrl.sm_idle;
    assign acq_enabled             = ctrl.acq_enabled;
    assign acq_done                = ctrl.acq_done;
    assign adc_mux_fill_hdr_sel    = ctrl.fill_hdr_sel;
    assign adc_mux_wfm_hdr_sel     = ctrl.wfm_hdr_sel;
    assign adc_mux_dat_sel         = ctrl.dat_sel;
    assign adc_mux_checksum_select = ctrl.checksum_select;
    assign adc_mux_checksum_update = ctrl.checksum_update;
    assign adc_acq_out_valid       = ctrl.out_valid;
    assign address_cntr_en         = ctrl.address_cntr_en;
    assign fill_cntr_en            = ctrl.fill_cntr_en;
    assign latch_circ_buf_dat      = ctrl.latch_dat;
    assign trig_addr_rd_en         = ctrl.rd_en;
    assign dummy_dat_reset         = ctrl.dummy_reset;

endmodule

// File: tb/tb_adc_acq_sm_cbuf_mw.sv
// Directed bench for adc_acq_sm_cbuf_mw: single fill, address wrap, multi-waveform,
// trigger-address timeout, enable loss mid-fill and reset mid-burst.
module tb_adc_acq_sm_cbuf_mw;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    acq_enable = '0;
    logic          acq_trig = 1'b0;
    logic [22:0]   burst_count = '0;
    logic [7:0]    wfm_count = '0;
    logic [AW-1:0] trig_addr;
    logic          trig_addr_empty;
    logic          ddr3_wr_done = 1'b0;
    logic          dummy_dat_reset_mode = 1'b0;
    logic [1:0]    fill_type;
    logic          trig_pulse, trig_addr_rd_en, latch_circ_buf_dat;
    logic [AW-1:0] circ_buf_rd_addr;
    logic          adc_mux_fill_hdr_sel, adc_mux_wfm_hdr_sel, adc_mux_dat_sel;
    logic          adc_mux_checksum_select, adc_mux_checksum_update, adc_acq_out_valid;
    logic          address_cntr_en, fill_cntr_en, dummy_dat_reset;
    logic          acq_enabled, acq_done, sm_idle, trig_addr_err;

    adc_acq_sm_cbuf_mw #(.TIMEOUT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .acq_enable(acq_enable), .acq_trig(acq_trig),
        .burst_count(burst_count), .wfm_count(wfm_count), .trig_addr(trig_addr),
        .trig_addr_empty(trig_addr_empty), .ddr3_wr_done(ddr3_wr_done),
        .dummy_dat_reset_mode(dummy_dat_reset_mode), .fill_type(fill_type),
        .trig_pulse(trig_pulse), .trig_addr_rd_en(trig_addr_rd_en),
        .circ_buf_rd_addr(circ_buf_rd_addr), .latch_circ_buf_dat(latch_circ_buf_dat),
        .adc_mux_fill_hdr_sel(adc_mux_fill_hdr_sel), .adc_mux_wfm_hdr_sel(adc_mux_wfm_hdr_sel),
        .adc_mux_dat_sel(adc_mux_dat_sel), .adc_mux_checksum_select(adc_mux_checksum_select),
        .adc_mux_checksum_update(adc_mux_checksum_update), .adc_acq_out_valid(adc_acq_out_valid),
        .address_cntr_en(address_cntr_en), .fill_cntr_en(fill_cntr_en),
        .dummy_dat_reset(dummy_dat_reset), .acq_enabled(acq_enabled), .acq_done(acq_done),
        .sm_idle(sm_idle), .trig_addr_err(trig_addr_err)
    );

    always #5 clk = ~clk;

    // First-word-fall-through FIFO model: the initial block pushes, the monitor pops.
    logic [AW-1:0] fifo_mem [8];
    logic [3:0]    wr_ptr = '0;
    logic [3:0]    rd_ptr = '0;
    assign trig_addr       = fifo_mem[rd_ptr[2:0]];
    assign trig_addr_empty = (rd_ptr == wr_ptr);

    int            cyc = 0, n_valid = 0, n_latch = 0, n_pop = 0, n_whdr = 0;
    int            n_fillcnt = 0, n_dummy = 0, n_datsel = 0, n_cksupd = 0;
    int            cyc_fhdr = 0, cyc_cks1 = 0;
    logic [AW-1:0] latch_log [$];

    always @(negedge clk) begin
        cyc++;
        if (adc_acq_out_valid)       n_valid++;
        if (fill_cntr_en)            n_fillcnt++;
        if (adc_mux_wfm_hdr_sel)     n_whdr++;
        if (dummy_dat_reset)         n_dummy++;
        if (adc_mux_dat_sel)         n_datsel++;
        if (adc_mux_checksum_update) n_cksupd++;
        if (adc_mux_fill_hdr_sel)    cyc_fhdr = cyc;
        if (adc_mux_checksum_select) cyc_cks1 = cyc;
        if (latch_circ_buf_dat) begin
            n_latch++;
            latch_log.push_back(circ_buf_rd_addr);
        end
        if (trig_addr_rd_en) begin
            n_pop++;
            rd_ptr = rd_ptr + 1'b1;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    localparam int W_DONE = 0, W_IDLE = 1, W_ENABLED = 2, W_FILLCNT = 3, W_LATCH = 4,
                   W_DATSEL = 5, W_TRIG = 6;

    function automatic logic pick(input int w);
        case (w)
            W_DONE:    return acq_done;
            W_IDLE:    return sm_idle;
            W_ENABLED: return acq_enabled;
            W_FILLCNT: return fill_cntr_en;
            W_LATCH:   return latch_circ_buf_dat;
            W_DATSEL:  return adc_mux_dat_sel;
            default:   return trig_pulse;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int w, input logic val, input int budget);
        int n = 0;
        while (pick(w) !== val && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(pick(w)), 32'(val));
    endtask

    task automatic push(input logic [AW-1:0] a);
        fifo_mem[wr_ptr[2:0]] = a;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    // Trigger, let the fill run to DDR3_WAIT, complete the DDR3 write, leave DONE.
    task automatic run_fill(input string tag, input int mid_wfm);
        acq_trig = 1'b1;
        wait_sig({tag, "_start"}, W_ENABLED, 1'b1, 30);
        if (mid_wfm >= 0) wfm_count = 8'(mid_wfm);
        wait_sig({tag, "_cks2"}, W_FILLCNT, 1'b1, 300);
        tick(3);
        check({tag, "_ddr3_hold"}, 32'(acq_done), 0);
        ddr3_wr_done = 1'b1;
        wait_sig({tag, "_done"}, W_DONE, 1'b1, 10);
        acq_trig     = 1'b0;
        ddr3_wr_done = 1'b0;
        wait_sig({tag, "_done_exit"}, W_DONE, 1'b0, 20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_valid, s_latch, s_pop, s_whdr, s_fill, s_dummy, s_dat, s_upd, v;

        // Reset state
        tick(4);
        check("rst_sm_idle", 32'(sm_idle), 1);
        check("rst_out_valid", 32'(adc_acq_out_valid), 0);
        check("rst_acq_enabled", 32'(acq_enabled), 0);
        check("rst_rd_addr", 32'(circ_buf_rd_addr), 0);
        check("rst_err", 32'(trig_addr_err), 0);
        reset_n = 1'b1;
        tick(3);

        // Single waveform, 3 bursts from 0x0100
        burst_count = 23'd3; wfm_count = 8'd1; dummy_dat_reset_mode = 1'b1;
        push(14'h0100);
        acq_enable = 2'b01;
        wait_sig("t1_armed", W_IDLE, 1'b0, 20);
        check("t1_armed_disabled", 32'(acq_enabled), 0);
        s_valid = n_valid; s_latch = n_latch; s_pop = n_pop; s_whdr = n_whdr;
        s_fill = n_fillcnt; s_dummy = n_dummy; s_dat = n_datsel; s_upd = n_cksupd;
        acq_trig = 1'b1;
        wait_sig("t1_trig_pulse", W_TRIG, 1'b1, 20);
        tick(1);
        check("t1_trig_pulse_width", 32'(trig_pulse), 0);
        check("t1_fill_hdr_sel", 32'(adc_mux_fill_hdr_sel), 1);
        check("t1_enabled", 32'(acq_enabled), 1);
        check("t1_fill_type", 32'(fill_type), 32'h1);
        tick(1);
        check("t1_fill_hdr2_valid", 32'(adc_acq_out_valid), 1);
        wait_sig("t1_cks2", W_FILLCNT, 1'b1, 200);
        tick(3);
        check("t1_ddr3_hold", 32'(acq_done), 0);
        ddr3_wr_done = 1'b1;
        wait_sig("t1_done", W_DONE, 1'b1, 10);
        check("t1_valid_cnt", 32'(n_valid - s_valid), 6);
        check("t1_latch_cnt", 32'(n_latch - s_latch), 12);
        check("t1_final_addr", 32'(circ_buf_rd_addr), 32'h010D);
        check("t1_first_latch_addr", 32'(latch_log[s_latch]), 32'h0101);
        check("t1_last_latch_addr", 32'(latch_log[s_latch+11]), 32'h010C);
        check("t1_pops", 32'(n_pop - s_pop), 1);
        check("t1_wfm_hdr", 32'(n_whdr - s_whdr), 1);
        check("t1_dummy_reset", 32'(n_dummy - s_dummy), 1);
        check("t1_dat_sel", 32'(n_datsel - s_dat), 3);
        check("t1_cks_update", 32'(n_cksupd - s_upd), 3);
        check("t1_fill_cntr", 32'(n_fillcnt - s_fill), 1);
        tick(5);
        check("t1_done_hold", 32'(acq_done), 1);
        acq_trig = 1'b0; ddr3_wr_done = 1'b0;
        wait_sig("t1_done_exit", W_DONE, 1'b0, 20);

        // Address wrap from 0x3FFE
        burst_count = 23'd1; wfm_count = 8'd1;
        push(14'h3FFE);
        tick(4);
        s_latch = n_latch; s_valid = n_valid;
        run_fill("t2", -1);
        check("t2_addr0", 32'(latch_log[s_latch]),   32'h3FFF);
        check("t2_addr1", 32'(latch_log[s_latch+1]), 32'h0000);
        check("t2_addr2", 32'(latch_log[s_latch+2]), 32'h0001);
        check("t2_addr3", 32'(latch_log[s_latch+3]), 32'h0002);
        check("t2_final_addr", 32'(circ_buf_rd_addr), 32'h0003);
        check("t2_valid_cnt", 32'(n_valid - s_valid), 4);

        // Three waveforms, wfm_count changed mid-fill, fill type 3
        acq_enable = 2'b11; burst_count = 23'd2; wfm_count = 8'd3; dummy_dat_reset_mode = 1'b0;
        push(14'h0200); push(14'h0400); push(14'h0600);
        tick(6);
        s_valid = n_valid; s_latch = n_latch; s_pop = n_pop; s_whdr = n_whdr;
        s_fill = n_fillcnt; s_dummy = n_dummy;
        run_fill("t3", 7);
        check("t3_pops", 32'(n_pop - s_pop), 3);
        check("t3_wfm_hdr", 32'(n_whdr - s_whdr), 3);
        check("t3_fill_cntr", 32'(n_fillcnt - s_fill), 1);
        check("t3_valid_cnt", 32'(n_valid - s_valid), 11);
        check("t3_latch_cnt", 32'(n_latch - s_latch), 24);
        check("t3_wfm2_addr", 32'(latch_log[s_latch+8]), 32'h0401);
        check("t3_final_addr", 32'(circ_buf_rd_addr), 32'h0609);
        check("t3_fill_type", 32'(fill_type), 32'h3);
        check("t3_no_dummy", 32'(n_dummy - s_dummy), 0);

        // Trigger-address FIFO stays empty: timeout after 15 waiting cycles
        wfm_count = 8'd2; burst_count = 23'd1;
        tick(4);
        s_valid = n_valid; s_latch = n_latch; s_pop = n_pop; s_whdr = n_whdr; s_fill = n_fillcnt;
        run_fill("t4", -1);
        check("t4_err", 32'(trig_addr_err), 1);
        check("t4_timeout_cycles", 32'(cyc_cks1 - cyc_fhdr), 17);
        check("t4_valid_cnt", 32'(n_valid - s_valid), 2);
        check("t4_fill_cntr", 32'(n_fillcnt - s_fill), 1);
        check("t4_pops", 32'(n_pop - s_pop), 0);
        check("t4_wfm_hdr", 32'(n_whdr - s_whdr), 0);
        check("t4_latch_cnt", 32'(n_latch - s_latch), 0);

        // Enable dropped and a second trigger during RUN
        wfm_count = 8'd1; burst_count = 23'd4;
        push(14'h0800);
        tick(4);
        s_valid = n_valid; s_latch = n_latch;
        acq_trig = 1'b1;
        wait_sig("t5_run", W_LATCH, 1'b1, 40);
        acq_trig = 1'b0;
        tick(6);
        acq_trig = 1'b1;
        tick(6);
        acq_enable = 2'b00;
        wait_sig("t5_cks2", W_FILLCNT, 1'b1, 100);
        ddr3_wr_done = 1'b1;
        wait_sig("t5_done", W_DONE, 1'b1, 10);
        wait_sig("t5_idle", W_IDLE, 1'b1, 10);
        ddr3_wr_done = 1'b0;
        check("t5_valid_cnt", 32'(n_valid - s_valid), 7);
        check("t5_latch_cnt", 32'(n_latch - s_latch), 16);
        check("t5_final_addr", 32'(circ_buf_rd_addr), 32'h0811);
        check("t5_err_cleared", 32'(trig_addr_err), 0);
        tick(10);
        check("t5_stay_idle", 32'(sm_idle), 1);
        check("t5_no_new_fill", 32'(n_valid - s_valid), 7);
        acq_enable = 2'b01;
        wait_sig("t5_rearm", W_IDLE, 1'b0, 20);
        check("t5_armed_disabled", 32'(acq_enabled), 0);
        tick(10);
        check("t5_no_stale_trig", 32'(acq_enabled), 0);

        // Reset asserted during BURST_WR
        acq_trig = 1'b0;
        tick(6);
        push(14'h0900);
        tick(1);
        acq_trig = 1'b1;
        wait_sig("t6_burst_sel", W_DATSEL, 1'b1, 60);
        tick(1);
        check("t6_burst_wr_valid", 32'(adc_acq_out_valid), 1);
        v = n_valid;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(adc_acq_out_valid), 0);
        check("t6_async_sm_idle", 32'(sm_idle), 1);
        check("t6_async_enabled", 32'(acq_enabled), 0);
        check("t6_async_addr", 32'(circ_buf_rd_addr), 0);
        check("t6_async_fill_type", 32'(fill_type), 0);
        check("t6_async_addr_cntr", 32'(address_cntr_en), 0);
        tick(5);
        check("t6_no_more_valid", 32'(n_valid - v), 0);
        acq_enable = 2'b00;
        reset_n = 1'b1;
        tick(4);
        check("t6_post_release_idle", 32'(sm_idle), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
